// File: rtl/tdm_scheduler_pkg.sv
// ============================================================================
//  Module      : tdm_pkg
//  Description : Shared types and sizes for the TDM channel scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tdm_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_GRANT = 2'd1;
    localparam logic [1:0] C_ST_GUARD = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = C_ST_IDLE,
        GRANT = C_ST_GRANT,
        GUARD = C_ST_GUARD
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tdm_scheduler_rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin pick, searching from last+1 upward.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import tdm_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] w_cand;

    // Walk from the farthest offset down so the nearest requester after last wins.
    always_comb begin
        found  = 1'b0;
        idx    = last;
        w_cand = last;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_cand = last + SEL_W'(i);
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tdm_scheduler.sv
// ============================================================================
//  Module      : tdm_scheduler
//  Description : Round-robin TDM channel scheduler with fixed-length slots.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_scheduler
    import tdm_pkg::*;
#(
    parameter int SLOT_LEN = 4,
    parameter int GUARD_EN = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] gnt,
    output logic               busy,
    output logic               slot_done,
    output logic [7:0]         frame_cnt
);

    localparam logic [3:0] C_LAST_CNT = 4'(SLOT_LEN - 1);
    localparam logic       C_ONE_CYC  = (SLOT_LEN == 1);
    localparam logic       C_GUARD    = (GUARD_EN != 0);

    state_t             r_state, w_state_nxt;
    logic [SEL_W-1:0]   r_sel, w_sel_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [3:0]         r_cnt, w_cnt_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_slot_done, w_slot_done_nxt;
    logic [7:0]         r_frame_cnt, w_frame_cnt_nxt;
    logic               r_have_last, w_have_last_nxt;

    logic               w_found;
    logic [SEL_W-1:0]   w_idx;
    logic               w_arb;
    logic               w_start;

    rr_pick u_rr_pick (
        .req   (req),
        .last  (r_sel),
        .found (w_found),
        .idx   (w_idx)
    );

    assign w_arb = en && w_found;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sel       <= '1;
            r_gnt       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_slot_done <= 1'b0;
            r_frame_cnt <= '0;
            r_have_last <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_gnt       <= w_gnt_nxt;
            r_cnt       <= w_cnt_nxt;
            r_busy      <= w_busy_nxt;
            r_slot_done <= w_slot_done_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_have_last <= w_have_last_nxt;
        end
    end

    // r_slot_done marks the current cycle as the final one of the slot.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_arb ? GRANT : IDLE;
            GRANT: begin
                if (r_slot_done) begin
                    if (C_GUARD) w_state_nxt = GUARD;
                    else         w_state_nxt = w_arb ? GRANT : IDLE;
                end
            end
            GUARD:   w_state_nxt = w_arb ? GRANT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_start = (w_state_nxt == GRANT) && ((r_state != GRANT) || r_slot_done);

    always_comb begin
        w_sel_nxt       = r_sel;
        w_gnt_nxt       = '0;
        w_cnt_nxt       = '0;
        w_busy_nxt      = (w_state_nxt != IDLE);
        w_slot_done_nxt = 1'b0;
        w_frame_cnt_nxt = r_frame_cnt;
        w_have_last_nxt = r_have_last;
        if (w_start) begin
            w_sel_nxt       = w_idx;
            w_gnt_nxt       = NUM_REQ'(1) << w_idx;
            w_slot_done_nxt = C_ONE_CYC;
            w_have_last_nxt = 1'b1;
            // A wrap back to the same or a lower index closes one round.
            if (r_have_last && (w_idx <= r_sel)) begin
                w_frame_cnt_nxt = r_frame_cnt + 8'd1;
            end
        end else if (w_state_nxt == GRANT) begin
            w_gnt_nxt       = r_gnt;
            w_cnt_nxt       = r_cnt + 4'd1;
            w_slot_done_nxt = ((r_cnt + 4'd1) == C_LAST_CNT) || !req[r_sel];
        end
    end

    assign sel       = r_sel;
    assign gnt       = r_gnt;
    assign busy      = r_busy;
    assign slot_done = r_slot_done;
    assign frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tdm_scheduler.sv
// ============================================================================
//  Module      : tb_tdm_scheduler
//  Description : Bench for tdm_scheduler, guarded and gapless variants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdm_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] req;

    logic [1:0] sel_g, sel_n;
    logic [3:0] gnt_g, gnt_n;
    logic       busy_g, busy_n, done_g, done_n;
    logic [7:0] fc_g, fc_n;

    always #5 clk = ~clk;

    tdm_scheduler #(.SLOT_LEN(4), .GUARD_EN(1)) u_dut_g (
        .clk(clk), .reset(reset), .en(en), .req(req),
        .sel(sel_g), .gnt(gnt_g), .busy(busy_g), .slot_done(done_g), .frame_cnt(fc_g)
    );

    tdm_scheduler #(.SLOT_LEN(4), .GUARD_EN(0)) u_dut_n (
        .clk(clk), .reset(reset), .en(en), .req(req),
        .sel(sel_n), .gnt(gnt_n), .busy(busy_n), .slot_done(done_n), .frame_cnt(fc_n)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: mode 0 idle, 1 holding the channel, 2 guard gap.
    int m_mode[2];
    int m_owner[2];
    int m_pos[2];
    int m_frames[2];
    bit m_final[2];
    bit m_any[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input int len, input bit guard);
        logic [1:0] cand;
        bit         found;
        int         w;
        if (reset) begin
            m_mode[k] = 0; m_owner[k] = 3; m_pos[k] = 0;
            m_frames[k] = 0; m_final[k] = 0; m_any[k] = 0;
            return;
        end
        if (m_mode[k] == 1 && !m_final[k]) begin
            m_pos[k]++;
            cand = 2'(m_owner[k]);
            m_final[k] = (m_pos[k] == len - 1) || !req[cand];
            return;
        end
        if (m_mode[k] == 1 && guard) begin
            m_mode[k] = 2; m_final[k] = 0;
            return;
        end
        found = 0; w = 0;
        for (int i = 1; i <= 4; i++) begin
            cand = 2'((m_owner[k] + i) % 4);
            if (!found && req[cand]) begin
                found = 1; w = int'(cand);
            end
        end
        if (en && found) begin
            if (m_any[k] && w <= m_owner[k]) m_frames[k] = (m_frames[k] + 1) % 256;
            m_owner[k] = w; m_any[k] = 1; m_mode[k] = 1; m_pos[k] = 0;
            m_final[k] = (len == 1);
        end else begin
            m_mode[k] = 0; m_final[k] = 0;
        end
    endtask

    task automatic compare_all();
        check("g_sel",  32'(sel_g),  m_owner[0]);
        check("g_gnt",  32'(gnt_g),  (m_mode[0] == 1) ? (32'd1 << m_owner[0]) : 32'd0);
        check("g_busy", 32'(busy_g), (m_mode[0] != 0) ? 32'd1 : 32'd0);
        check("g_done", 32'(done_g), 32'(m_final[0]));
        check("g_fcnt", 32'(fc_g),   m_frames[0]);
        check("g_onehot", ($countones(gnt_g) <= 1) ? 32'd1 : 32'd0, 32'd1);
        check("n_sel",  32'(sel_n),  m_owner[1]);
        check("n_gnt",  32'(gnt_n),  (m_mode[1] == 1) ? (32'd1 << m_owner[1]) : 32'd0);
        check("n_busy", 32'(busy_n), (m_mode[1] != 0) ? 32'd1 : 32'd0);
        check("n_done", 32'(done_n), 32'(m_final[1]));
        check("n_fcnt", 32'(fc_n),   m_frames[1]);
        check("n_onehot", ($countones(gnt_n) <= 1) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, 4, 1'b1);
        model_step(1, 4, 1'b0);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int         starts[8];
        int         fcs[8];
        int         nst;
        int         bad;
        int         ndone;
        logic [3:0] prev;

        reset = 1'b1; en = 1'b0; req = 4'h0;
        tick(); tick();
        check("rst_sel",  32'(sel_g),  32'd3);
        check("rst_gnt",  32'(gnt_g),  32'd0);
        check("rst_busy", 32'(busy_g), 32'd0);
        check("rst_fcnt", 32'(fc_g),   32'd0);

        // All four requesting: 0,1,2,3,0 with a guard gap between slots.
        reset = 1'b0; en = 1'b1; req = 4'hF;
        nst = 0; prev = 4'h0;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (gnt_g != 4'h0 && prev == 4'h0 && nst < 8) begin
                starts[nst] = int'(sel_g); fcs[nst] = int'(fc_g); nst++;
            end
            prev = gnt_g;
        end
        check("seq_count", 32'(nst), 32'd5);
        for (int i = 0; i < 5 && i < nst; i++) check("seq_idx", 32'(starts[i]), 32'(i % 4));
        if (nst >= 5) begin
            check("seq_fcnt_first", 32'(fcs[0]), 32'd0);
            check("seq_fcnt_wrap",  32'(fcs[4]), 32'd1);
        end

        // Only odd requesters: even ones must never see a grant.
        req = 4'b1010; bad = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (gnt_g[0] || gnt_g[2] || gnt_n[0] || gnt_n[2]) bad++;
        end
        check("odd_only", 32'(bad), 32'd0);

        // Single requester without guard: continuous grant, slot_done every 4 cycles.
        reset = 1'b1; req = 4'b0001; tick();
        reset = 1'b0; tick();
        bad = 0; ndone = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (gnt_n != 4'b0001) bad++;
            if (done_n) ndone++;
        end
        check("solo_gnt", 32'(bad), 32'd0);
        check("solo_done", 32'(ndone), 32'd4);

        // en dropped during slot cycle 0: slot still runs to completion.
        reset = 1'b1; req = 4'hF; en = 1'b1; tick();
        reset = 1'b0; tick();
        en = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        check("en_hold_gnt", 32'(gnt_g), 32'd1);
        check("en_hold_done", 32'(done_g), 32'd1);
        tick(); tick();
        check("en_idle_gnt", 32'(gnt_g), 32'd0);
        check("en_idle_busy", 32'(busy_g), 32'd0);

        // Reset in the middle of a slot, then first grant goes to requester 0.
        en = 1'b1; tick(); tick(); tick();
        reset = 1'b1; tick();
        check("mid_rst_gnt",  32'(gnt_g),  32'd0);
        check("mid_rst_sel",  32'(sel_g),  32'd3);
        check("mid_rst_done", 32'(done_g), 32'd0);
        reset = 1'b0; tick();
        check("post_rst_gnt", 32'(gnt_g), 32'd1);

        // Randomized traffic against the reference.
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            en    = ($urandom_range(0, 9) != 0);
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
